// File: rtl/drw_pkg.sv
// ----------------------------------------------------------------------------
// drw_pkg
// Shared definitions for the draw-engine command sequencer.
//   - opcode constants for the command headers
//   - FSM state encoding used by drw_cmdseq
//   - bit positions inside the sticky ERRNO register
//   - op_arg_count(): number of argument words that follow a header
// ----------------------------------------------------------------------------
package drw_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_SETFRAME = 4'h1;
    localparam logic [3:0] OP_SETCOLOR = 4'h2;
    localparam logic [3:0] OP_PATBLT   = 4'h3;
    localparam logic [3:0] OP_END      = 4'hF;

    localparam int ERR_ILLOP = 0;
    localparam int ERR_TRUNC = 1;
    localparam int ERR_TMO   = 2;

    // Width of the argument counter; large enough for the biggest opcode (2).
    localparam int ARGC_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HDR,
        S_ARGF,
        S_ARGL,
        S_ISSUE,
        S_DRAIN,
        S_ERR
    } state_t;

    // Illegal opcodes report 0 here; legality is judged separately.
    function automatic logic [ARGC_W-1:0] op_arg_count(input logic [3:0] op);
        logic [ARGC_W-1:0] n;
        case (op)
            OP_SETFRAME: n = 2'd1;
            OP_SETCOLOR: n = 2'd1;
            OP_PATBLT:   n = 2'd2;
            default:     n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/drw_cmd_decode.sv
// ----------------------------------------------------------------------------
// drw_cmd_decode
// Purely combinational header decoder.
// Ports:
//   hdr_top    in   8  header word bits [31:24] (reserved nibble + opcode)
//   legal      out  1  header is a known opcode with a zero reserved nibble
//   arg_count  out  2  argument words that follow this header
//   issue      out  1  command is forwarded to the datapath (not NOP/END)
// ----------------------------------------------------------------------------
module drw_cmd_decode
    import drw_pkg::*;
(
    input  logic [7:0]        hdr_top,
    output logic              legal,
    output logic [ARGC_W-1:0] arg_count,
    output logic              issue
);

    logic [3:0] op;
    assign op = hdr_top[3:0];

    always_comb begin
        legal     = 1'b0;
        issue     = 1'b0;
        arg_count = op_arg_count(op);
        case (op)
            OP_NOP, OP_END: begin
                legal = 1'b1;
            end
            OP_SETFRAME, OP_SETCOLOR, OP_PATBLT: begin
                legal = 1'b1;
                issue = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // A non-zero reserved nibble poisons any opcode.
        if (hdr_top[7:4] != 4'h0) begin
            legal = 1'b0;
            issue = 1'b0;
        end
    end

endmodule

// File: rtl/drw_cmdseq.sv
// ----------------------------------------------------------------------------
// drw_cmdseq
// Command sequencer: pops header/argument words from the command FIFO while
// EXE is high, issues one command per valid/ready handshake, and pulses
// DRAW_FINISH after an END once the datapath is idle.
// Optional build macro: DRW_TIMEOUT_EN adds a watchdog on the ISSUE, ARGF and
// DRAIN wait states (sets ERRNO[2] and parks in ERR on expiry).
// Ports:
//   ACLK, ARST        clock, async active-high reset
//   RST               synchronous soft reset (highest priority)
//   EXE               execute enable level
//   FIFO_RD/DOUT/EMPTY  FIFO read side (data valid the cycle after FIFO_RD)
//   CMD_VALID/READY   command handshake to the datapath
//   CMD_OP/HDR/ARG0/ARG1  command payload, stable while CMD_VALID
//   DP_IDLE           datapath has nothing in flight
//   DRAW_FINISH       one-cycle end-of-list pulse
//   ERRNO             sticky error flags (bit0 illegal, bit1 truncated, bit2 timeout)
//   BUSY              FSM not in IDLE
// ----------------------------------------------------------------------------
module drw_cmdseq
    import drw_pkg::*;
#(
    parameter int MAX_ARGS    = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        RST,
    input  logic        EXE,
    output logic        FIFO_RD,
    input  logic [31:0] FIFO_DOUT,
    input  logic        FIFO_EMPTY,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [3:0]  CMD_OP,
    output logic [23:0] CMD_HDR,
    output logic [31:0] CMD_ARG0,
    output logic [31:0] CMD_ARG1,
    input  logic        DP_IDLE,
    output logic        DRAW_FINISH,
    output logic [15:0] ERRNO,
    output logic        BUSY
);

    state_t                       state;
    logic                         cmd_valid;
    logic [3:0]                   cmd_op;
    logic [23:0]                  cmd_hdr;
    logic [MAX_ARGS-1:0][31:0]    arg_q;
    logic [ARGC_W-1:0]            arg_cnt;
    logic [ARGC_W-1:0]            arg_idx;
    logic                         draw_finish;
    logic [2:0]                   errno_q;
    logic                         tmo_hit;

    logic                         dec_legal;
    logic                         dec_issue;
    logic [ARGC_W-1:0]            dec_args;

    drw_cmd_decode u_decode (
        .hdr_top   (FIFO_DOUT[31:24]),
        .legal     (dec_legal),
        .arg_count (dec_args),
        .issue     (dec_issue)
    );

    // The pop strobe is decoded from the current state so the word lands on
    // FIFO_DOUT exactly while the FSM sits in HDR/ARGL. It is qualified by
    // !FIFO_EMPTY so an empty FIFO is never popped, and by !RST so a soft
    // reset does not silently consume a word.
    assign FIFO_RD = !RST && !FIFO_EMPTY &&
                     ((state == S_FETCH && EXE) || state == S_ARGF);

`ifdef DRW_TIMEOUT_EN
    // Watchdog: counts consecutive cycles spent stalled in a wait state and
    // restarts whenever the FSM moves on, so each wait gets a fresh budget.
    localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYC - 1);

    logic [20:0] tmo_cnt;
    logic        stalled;

    assign stalled = (state == S_ISSUE && !CMD_READY) ||
                     (state == S_ARGF  && FIFO_EMPTY) ||
                     (state == S_DRAIN && !DP_IDLE);

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            tmo_cnt <= '0;
        end else if (RST || !stalled) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 21'd1;
        end
    end

    assign tmo_hit = stalled && (tmo_cnt == TMO_LAST);
`else
    // No watchdog is built; the expiry term can never be true.
    assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

    // Main sequencer. Async and soft reset clear the same set of registers;
    // the soft reset wins over every other event in its cycle.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state       <= S_IDLE;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_hdr     <= '0;
            arg_q       <= '0;
            arg_cnt     <= '0;
            arg_idx     <= '0;
            draw_finish <= 1'b0;
            errno_q     <= '0;
        end else if (RST) begin
            state       <= S_IDLE;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_hdr     <= '0;
            arg_q       <= '0;
            arg_cnt     <= '0;
            arg_idx     <= '0;
            draw_finish <= 1'b0;
            errno_q     <= '0;
        end else begin
            draw_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (EXE) state <= S_FETCH;
                end

                S_FETCH: begin
                    if (!EXE) begin
                        state <= S_IDLE;
                    end else if (!FIFO_EMPTY) begin
                        state <= S_HDR;
                    end
                end

                S_HDR: begin
                    cmd_op  <= FIFO_DOUT[27:24];
                    cmd_hdr <= FIFO_DOUT[23:0];
                    if (!dec_legal) begin
                        errno_q[ERR_ILLOP] <= 1'b1;
                        state              <= S_ERR;
                    end else if (!dec_issue) begin
                        state <= (FIFO_DOUT[27:24] == OP_END) ? S_DRAIN : S_FETCH;
                    end else begin
                        // Clear stale arguments so unused ARG words read as 0.
                        arg_q   <= '0;
                        arg_cnt <= dec_args;
                        arg_idx <= '0;
                        if (dec_args == '0) begin
                            cmd_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            state <= S_ARGF;
                        end
                    end
                end

                S_ARGF: begin
                    if (!EXE) errno_q[ERR_TRUNC] <= 1'b1;
                    if (!FIFO_EMPTY) begin
                        state <= S_ARGL;
                    end else if (tmo_hit) begin
                        errno_q[ERR_TMO] <= 1'b1;
                        state            <= S_ERR;
                    end
                end

                S_ARGL: begin
                    if (!EXE) errno_q[ERR_TRUNC] <= 1'b1;
                    for (int i = 0; i < MAX_ARGS; i++) begin
                        if (arg_idx == ARGC_W'(i)) arg_q[i] <= FIFO_DOUT;
                    end
                    arg_idx <= arg_idx + 1'b1;
                    arg_cnt <= arg_cnt - 1'b1;
                    if (arg_cnt == ARGC_W'(1)) begin
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        state <= S_ARGF;
                    end
                end

                S_ISSUE: begin
                    if (CMD_READY) begin
                        cmd_valid <= 1'b0;
                        state     <= S_FETCH;
                    end else if (tmo_hit) begin
                        errno_q[ERR_TMO] <= 1'b1;
                        cmd_valid        <= 1'b0;
                        state            <= S_ERR;
                    end
                end

                S_DRAIN: begin
                    if (DP_IDLE) begin
                        draw_finish <= 1'b1;
                        state       <= S_IDLE;
                    end else if (tmo_hit) begin
                        errno_q[ERR_TMO] <= 1'b1;
                        state            <= S_ERR;
                    end
                end

                S_ERR: begin
                    state <= S_ERR;
                end

                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

    assign CMD_VALID   = cmd_valid;
    assign CMD_OP      = cmd_op;
    assign CMD_HDR     = cmd_hdr;
    assign CMD_ARG0    = arg_q[0];
    assign CMD_ARG1    = arg_q[1];
    assign DRAW_FINISH = draw_finish;
    assign ERRNO       = {13'b0, errno_q};
    assign BUSY        = (state != S_IDLE);

endmodule
